// File: rtl/audio_dac_i2s_tx_if.sv
// ============================================================================
//  Module   : audio_dac_i2s_tx_if
//  Brief    : Mixer-side sample bus and DAC-side I2S pins of audio_dac_i2s_tx.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface audio_dac_i2s_tx_if;
    logic signed [15:0] audio_l;
    logic signed [15:0] audio_r;
    logic               mute;
    logic               sample_strobe;
    logic               i2s_bck;
    logic               i2s_ws;
    logic               i2s_data;

    // master = sample source (mixer / bench), slave = the transmitter
    modport master (
        output audio_l, audio_r, mute,
        input  sample_strobe, i2s_bck, i2s_ws, i2s_data
    );

    modport slave (
        input  audio_l, audio_r, mute,
        output sample_strobe, i2s_bck, i2s_ws, i2s_data
    );
endinterface

`default_nettype wire

// File: rtl/audio_dac_i2s_tx.sv
// ============================================================================
//  Module   : audio_dac_i2s_tx
//  Brief    : Serialises a signed 16-bit stereo sample pair onto a 3-wire I2S
//             link; BCK and WS are derived from clk (Fs = f_clk/(64*HALF_DIV)).
//             Define I2S_TX_LEFT_JUSTIFIED_EN for left-justified framing.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module audio_dac_i2s_tx #(
    parameter int HALF_DIV = 8
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    audio_dac_i2s_tx_if.slave  bus
);

    localparam logic [7:0] DIV_LAST = 8'(HALF_DIV - 1);

    logic [7:0]  div_cnt;
    logic [4:0]  bit_cnt;
    logic [31:0] shift_reg;
    logic        bck;
    logic        ws;
    logic        data;
    logic        strobe;

    logic        div_tc;
    logic        fall_event;
    logic        frame_start;
    logic [4:0]  bit_cnt_next;
    logic [31:0] frame_word;

    always_comb begin
        div_tc       = (div_cnt == DIV_LAST);
        fall_event   = div_tc && bck;
        frame_start  = fall_event && (bit_cnt == 5'd31);
        bit_cnt_next = bit_cnt + 5'd1;
        frame_word   = bus.mute ? 32'h0 : {bus.audio_l, bus.audio_r};
    end

    // Prescaler and bit clock
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= 8'd0;
            bck     <= 1'b0;
        end else begin
            div_cnt <= div_tc ? 8'd0 : div_cnt + 8'd1;
            if (div_tc) begin
                bck <= ~bck;
            end
        end
    end

    // Slot counter, word select and the latch strobe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt <= 5'd31;
            ws      <= 1'b0;
            strobe  <= 1'b0;
        end else begin
            strobe <= frame_start;
            if (fall_event) begin
                bit_cnt <= bit_cnt_next;
                ws      <= bit_cnt_next[4];
            end
        end
    end

    // Serialiser. In I2S mode the word is shifted out one slot late; after 31
    // shifts the right LSB sits in bit 31, so it doubles as the held bit that
    // is driven at the next frame's slot 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_reg <= 32'h0;
            data      <= 1'b0;
        end else if (fall_event) begin
            if (frame_start) begin
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
                data      <= frame_word[31];
                shift_reg <= {frame_word[30:0], 1'b0};
`else
                data      <= shift_reg[31];
                shift_reg <= frame_word;
`endif
            end else begin
                data      <= shift_reg[31];
                shift_reg <= {shift_reg[30:0], 1'b0};
            end
        end
    end

    assign bus.sample_strobe = strobe;
    assign bus.i2s_bck       = bck;
    assign bus.i2s_ws        = ws;
    assign bus.i2s_data      = data;

endmodule

`default_nettype wire

// File: tb/tb_audio_dac_i2s_tx.sv
// ============================================================================
//  Module   : tb_audio_dac_i2s_tx
//  Brief    : Self-checking bench for audio_dac_i2s_tx; a slot/frame timeline
//             model predicts every output each clock.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_audio_dac_i2s_tx;

    localparam int H  = 2;
    localparam int FR = 64 * H;
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
    localparam bit LJ = 1'b1;
`else
    localparam bit LJ = 1'b0;
`endif

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic        mute;
        int          chg_slot;
        logic [31:0] exp_word;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;
    audio_dac_i2s_tx_if bus ();

    audio_dac_i2s_tx #(.HALF_DIV(H)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    int          nvec = 0;
    int          nerr = 0;
    int          c    = 0;
    logic        prev_bck = 1'b0;
    logic [31:0] words[$];
    logic        cap_d[0:2047];
    vec_t        tbl[6];

    function automatic int cur_slot();
        return c / (2 * H) - 1;
    endfunction

    function automatic logic [31:0] cap_word(int f);
        logic [31:0] w;
        for (int s = 0; s < 32; s++) begin
            if (LJ) w[31 - s] = cap_d[32 * f + s];
            else    w[31 - s] = cap_d[32 * f + s + 1];
        end
        return w;
    endfunction

    task automatic clear_model();
        c        = 0;
        prev_bck = 1'b0;
        words.delete();
        for (int i = 0; i < 2048; i++) cap_d[i] = 1'bx;
    endtask

    // Advance one clock, then compare all outputs to the timeline model.
    task automatic tick();
        logic [3:0] expv;
        logic [3:0] got;
        int g, f, s;
        @(negedge clk);
        c++;
        expv = 4'b0;
        if (c >= 2 * H && (c - 2 * H) % FR == 0)
            words.push_back(bus.mute ? 32'h0 : {bus.audio_l, bus.audio_r});
        expv[3] = (c >= 2 * H) && ((c - 2 * H) % FR == 0);
        expv[2] = ((c / H) % 2) == 1;
        if (c >= 2 * H) begin
            g = cur_slot();
            f = g / 32;
            s = g % 32;
            expv[1] = (s >= 16);
            if (LJ)          expv[0] = words[f][31 - s];
            else if (s == 0) expv[0] = (f == 0) ? 1'b0 : words[f - 1][0];
            else             expv[0] = words[f][32 - s];
            if (bus.i2s_bck && !prev_bck && g < 2048) cap_d[g] = bus.i2s_data;
        end
        got = {bus.sample_strobe, bus.i2s_bck, bus.i2s_ws, bus.i2s_data};
        nvec++;
        if (got !== expv) begin
            nerr++;
            $display("FAIL cycle c=%0d {strobe,bck,ws,data} got %b expected %b", c, got, expv);
        end
        prev_bck = bus.i2s_bck;
    endtask

    task automatic run_to_slot(int gt);
        while (c < 2 * H * (gt + 1)) tick();
    endtask

    task automatic check_zero(string name);
        logic [3:0] got;
        got = {bus.sample_strobe, bus.i2s_bck, bus.i2s_ws, bus.i2s_data};
        nvec++;
        if (got !== 4'b0) begin
            nerr++;
            $display("FAIL %s {strobe,bck,ws,data} got %b expected 0000", name, got);
        end
    endtask

    task automatic check_word(string name, int f, logic [31:0] expw);
        logic [31:0] gotw;
        gotw = cap_word(f);
        nvec++;
        if (gotw !== expw) begin
            nerr++;
            $display("FAIL %s frame %0d word got %h expected %h", name, f, gotw, expw);
        end
    endtask

    task automatic set_random_inputs();
        bus.audio_l = 16'($urandom);
        bus.audio_r = 16'($urandom);
        bus.mute    = ($urandom_range(0, 3) == 0);
    endtask

    task automatic wait_first_strobe(string name);
        bit got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            tick();
            if (bus.sample_strobe) got = 1'b1;
        end
        nvec++;
        if (!got || c != 2 * H) begin
            nerr++;
            $display("FAIL %s first strobe at clk %0d (seen=%0d) expected clk %0d", name, c, got, 2 * H);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{16'hA55A, 16'h0F0F, 1'b0,  8, 32'hA55A0F0F};
        tbl[1] = '{16'h8000, 16'h0F0F, 1'b0, 20, 32'h80000F0F};
        tbl[2] = '{16'h1234, 16'h5678, 1'b1,  5, 32'h00000000};
        tbl[3] = '{16'h8001, 16'h7FFE, 1'b0,  8, 32'h80017FFE};
        tbl[4] = '{16'hFFFF, 16'h0001, 1'b0, 13, 32'hFFFF0001};
        tbl[5] = '{16'h0000, 16'hFFFF, 1'b0, 30, 32'h0000FFFF};

        // Power-up reset
        reset_n     = 1'b0;
        bus.audio_l = tbl[0].l;
        bus.audio_r = tbl[0].r;
        bus.mute    = tbl[0].mute;
        clear_model();
        repeat (3) begin
            @(negedge clk);
            check_zero("reset_hold");
        end
        reset_n = 1'b1;

        // Table frames; inputs for the next frame are applied mid-frame
        wait_first_strobe("power_up");
        for (int i = 0; i < 6; i++) begin
            run_to_slot(32 * i + tbl[i].chg_slot);
            if (i < 5) begin
                bus.audio_l = tbl[i + 1].l;
                bus.audio_r = tbl[i + 1].r;
                bus.mute    = tbl[i + 1].mute;
            end else begin
                set_random_inputs();
            end
        end
        run_to_slot(32 * 6 + 1);
        for (int i = 0; i < 6; i++) check_word("table", i, tbl[i].exp_word);

        // Random frames against the model
        for (int fr = 6; fr < 14; fr++) begin
            run_to_slot(32 * fr + int'($urandom_range(2, 31)));
            set_random_inputs();
        end
        run_to_slot(32 * 14 + 1);
        for (int fr = 6; fr < 14; fr++) check_word("random", fr, words[fr]);

        // Asynchronous reset in the middle of a frame
        run_to_slot(32 * 14 + 10);
        #2;
        reset_n = 1'b0;
        #1;
        check_zero("async_reset");
        repeat (3) begin
            @(negedge clk);
            check_zero("reset_pulse");
        end
        reset_n = 1'b1;
        clear_model();
        set_random_inputs();
        wait_first_strobe("after_reset");
        for (int fr = 0; fr < 3; fr++) begin
            run_to_slot(32 * fr + int'($urandom_range(2, 31)));
            set_random_inputs();
        end
        run_to_slot(32 * 3 + 1);
        for (int fr = 0; fr < 3; fr++) check_word("post_reset", fr, words[fr]);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/audio_dac_i2s_tx.md
Name: audio_dac_i2s_tx

Overview:
- Consumer end of the mixer output: serialises the signed 16-bit stereo mix (audio_l/audio_r) to an external audio DAC over a 3-wire I2S link.
- Generates BCK and WS internally from clk. Latches one stereo sample per frame and emits a strobe at that latch.
- Sits between the audio mixer and the board DAC pins.

Parameters:
HALF_DIV, 8, clk cycles per BCK half-period (legal range 2..255); Fs = f_clk / (64*HALF_DIV)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
audio_l  in  16  signed left sample, two's complement
audio_r  in  16  signed right sample
mute  in  1  1 = transmit zeros from the next frame
sample_strobe  out  1  1-clk pulse when audio_l/audio_r/mute are latched
i2s_bck  out  1  bit clock; DAC samples data on the rising edge
i2s_ws  out  1  word select; 0 = left, 1 = right
i2s_data  out  1  serial data, MSB first

Behaviour:
- Reset (async on reset_n=0, immediate): i2s_bck=0, i2s_ws=0, i2s_data=0, sample_strobe=0, div_cnt=0, bit_cnt=31, shift register=0. All outputs are registered.
- Prescaler:
  - div_cnt counts 0..HALF_DIV-1 and wraps.
  - At terminal count, i2s_bck toggles.
  - "Fall event" = the cycle at terminal count with i2s_bck currently 1.
  - First rise occurs HALF_DIV clks after reset release; first fall event occurs at 2*HALF_DIV clks.
- On each fall event: bit_cnt increments mod 32; all data/ws updates happen only on fall events.
- Frame start is the fall event where bit_cnt goes 31→0. In that cycle:
  - Latch {audio_l, audio_r}, or 32'h0 if mute=1, into a 32-bit shift register.
  - Assert sample_strobe for exactly this one cycle.
  - Inputs are sampled only here; changes mid-frame are ignored.
- i2s_ws = 0 for bit_cnt 0..15 and 1 for 16..31, updated on the fall event.
- i2s_data (standard I2S):
  - At slot k, the output is frame bit k-1.
  - Left MSB appears at slot 1, left LSB at slot 16, right MSB at slot 17, right LSB at slot 0 of the next frame.
  - Requires one held bit: the previous frame's right LSB is output at slot 0.
  - The first frame after reset outputs 0 at slot 0.
- Timing:
  - Latency from strobe to left MSB on i2s_data: 1 BCK period.
  - Frame period: exactly 64*HALF_DIV clks.
  - Strobe spacing: exactly 64*HALF_DIV clks.
- Width rules: samples are passed bit-exact. No saturation, scaling or sign manipulation.
- Mute: takes effect only at a frame start. A frame already in progress completes with its latched data. Deasserting mute also takes effect at the next frame start.
- Reset mid-frame: outputs drop to 0 asynchronously. After release the timeline restarts exactly as after power-up; no partial frame resumes.

Optional Feature:
Macro I2S_TX_LEFT_JUSTIFIED_EN.
- Defined: left-justified format. No 1-bit delay: left MSB at slot 0, left LSB at slot 15, right MSB at slot 16, right LSB at slot 31. No held bit. Strobe-to-MSB latency is 0 BCK (MSB driven in the strobe cycle). WS timing is unchanged.
- Undefined: standard I2S as in Behaviour.

Test Plan:
- Reset, HALF_DIV=2: hold reset_n=0 → bck/ws/data/strobe all 0. Release → first bck rise after 2 clks; first sample_strobe at clk 4; bck period 4 clks.
- audio_l=16'hA55A, audio_r=16'h0F0F, I2S mode: capture data on bck rising edges. Expect slots 1..16 = A55A MSB-first with ws=0; slots 17..31 plus next slot 0 = 0F0F with ws=1; next slot 0 carries R LSB=1.
- Change audio_l to 16'h8000 at slot 8: current frame still sends A55A. Next frame sends 8000 with its MSB at slot 1. Strobe spacing stays 64*HALF_DIV clks.
- mute=1 asserted at slot 20: current frame completes unchanged. Next frame is all zeros. Release mute at slot 5 → the following frame carries input data.
- Pulse reset_n low for 3 clks at slot 10: outputs go to 0 in the same cycle. After release, the first strobe arrives at 2*HALF_DIV clks and a clean frame follows.
- With I2S_TX_LEFT_JUSTIFIED_EN, L=16'h8001, R=16'h7FFE: data=1 at slot 0, 1 at slot 15, 0 at slot 16, 0 at slot 31; ws transitions at slots 0 and 16.
